// File: rtl/stepper_ctrl_pkg.sv
// Shared definitions for the stepper move controller: one-hot state encoding,
// default parameter values and a small elaboration-time helper.
// Ports: none (package). Optional position counter is gated by STEPPER_POS_EN.
package stepper_ctrl_pkg;

  localparam int DEF_STEP_W     = 16;
  localparam int DEF_DIV_CYC    = 50000;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 1000;
  localparam int DEF_POS_W      = 24;

  // One-hot controller states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETTLE = 4'b0010,
    ST_RUN    = 4'b0100,
    ST_HOLD   = 4'b1000
  } state_e;

  // Largest of three cycle counts; sizes the shared timing counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Purpose : shared cycle counter with a programmable terminal value (load_i),
//           used for settle, step-rate and holding-torque timing.
// Latency : tc_o/near_tc_o are decoded from the counter register (same cycle).
// Backpressure: none; clr_i wins over en_i, counter wraps to 0 at terminal.
// Ports   : clk, rst (async high), clr_i, en_i, load_i[CNT_W] (terminal value),
//           tc_o (count == load), near_tc_o (count == load-1, terminal next cycle).
module step_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             tc_o,
  output logic             near_tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == load_i);
  // Lookahead lets the owner register a pulse that lands on the terminal cycle.
  assign near_tc_o = ((cnt_q + CNT_W'(1)) == load_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Purpose : per-joint move sequencer driving a phase-sequencing stepper
//           (onoff, cwccw, fushs, one-cycle step_en) with settle, rate, hold, abort.
// Latency : all outputs registered; first step_en DIV_CYC cycles into RUN,
//           done one cycle after HOLD expires (or the cycle after a null-move accept).
// Backpressure: cmd_ready high only in IDLE; cmd_valid while busy is dropped.
// Ports   : clk, rst (async high); cmd_valid/cmd_ready/cmd_steps/cmd_dir/cmd_half;
//           abort; step_en, cwccw, fushs, onoff, busy, done, aborted,
//           steps_left[STEP_W], position[POS_W].
// Config  : define STEPPER_POS_EN to build the signed position counter;
//           otherwise position is tied to 0.
module stepper_move_ctrl
  import stepper_ctrl_pkg::*;
#(
  parameter int STEP_W     = DEF_STEP_W,
  parameter int DIV_CYC    = DEF_DIV_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int POS_W      = DEF_POS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic              abort,
  output logic              step_en,
  output logic              cwccw,
  output logic              fushs,
  output logic              onoff,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left,
  output logic [POS_W-1:0]  position
);

  localparam int MAX_CYC = max3(DIV_CYC, SETTLE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e state_q;
  state_e state_d;

  logic              step_en_q;
  logic              cwccw_q;
  logic              fushs_q;
  logic              onoff_q;
  logic              busy_q;
  logic              cmd_ready_q;
  logic              done_q;
  logic              done_d;
  logic              aborted_q;
  logic [STEP_W-1:0] steps_left_q;

  logic              accept;
  logic              fire;
  logic              abort_hit;
  logic              pre_clr;
  logic              pre_tc;
  logic              pre_near;
  logic [CNT_W-1:0]  pre_load;

  // ---------------------------------------------------------------------------
  // Shared timing counter: terminal value follows the current state and the
  // count restarts from 0 on every state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_load = HOLD_LD;
    if (state_q == ST_RUN) begin
      pre_load = DIV_LD;
    end else if (state_q == ST_SETTLE) begin
      pre_load = SETTLE_LD;
    end
  end

  assign pre_clr = (state_d != state_q);

  step_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (pre_clr),
    .en_i      (busy_q),
    .load_i    (pre_load),
    .tc_o      (pre_tc),
    .near_tc_o (pre_near)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // step_en is a registered output, so the step is decided in the cycle before
  // the prescaler terminal count and the pulse lands on the terminal cycle.
  // An abort sampled on that deciding cycle suppresses the step entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    fire      = 1'b0;
    abort_hit = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept = 1'b1;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = ST_HOLD;
        end else if (pre_tc) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          fire = pre_near && (steps_left_q != '0);
          // Leave only once the final pulse has been presented.
          if (step_en_q && (steps_left_q == '0)) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (pre_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_en_q    <= 1'b0;
      cwccw_q      <= 1'b0;
      fushs_q      <= 1'b0;
      onoff_q      <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      steps_left_q <= '0;
    end else begin
      state_q     <= state_d;
      step_en_q   <= fire;
      onoff_q     <= (state_d != ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      cmd_ready_q <= (state_d == ST_IDLE);
      done_q      <= done_d;

      // Direction and mode are only written on accept, so they stay frozen
      // for the whole move.
      if (accept) begin
        cwccw_q      <= cmd_dir;
        fushs_q      <= cmd_half;
        steps_left_q <= cmd_steps;
        aborted_q    <= 1'b0;
      end else begin
        if (fire) begin
          steps_left_q <= steps_left_q - STEP_W'(1);
        end
        if (abort_hit) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  assign step_en    = step_en_q;
  assign cwccw      = cwccw_q;
  assign fushs      = fushs_q;
  assign onoff      = onoff_q;
  assign busy       = busy_q;
  assign cmd_ready  = cmd_ready_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_left_q;

  // ---------------------------------------------------------------------------
  // Absolute position, in whatever unit (full or half step) each move used.
  // Updated on the same edge as the step pulse; survives aborts and new moves.
  // ---------------------------------------------------------------------------
`ifdef STEPPER_POS_EN
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  always_comb begin
    pos_d = pos_q;
    if (fire) begin
      pos_d = cwccw_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`else
  assign position = '0;
`endif

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl (DIV_CYC=4, SETTLE_CYC=2, HOLD_CYC=3).
// Stimulus pushes the expected step_en/done events; a negedge monitor pops and
// compares them whenever the DUT pulses step_en or done.
module tb_stepper_move_ctrl;

  localparam int STEP_W = 16;
  localparam int DIV    = 4;
  localparam int SET    = 2;
  localparam int HLD    = 3;
  localparam int POS_W  = 24;

`ifdef STEPPER_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              cmd_dir = 1'b0;
  logic              cmd_half = 1'b0;
  logic              abort = 1'b0;
  logic              step_en;
  logic              cwccw;
  logic              fushs;
  logic              onoff;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_left;
  logic [POS_W-1:0]  position;

  stepper_move_ctrl #(
    .STEP_W     (STEP_W),
    .DIV_CYC    (DIV),
    .SETTLE_CYC (SET),
    .HOLD_CYC   (HLD),
    .POS_W      (POS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_half   (cmd_half),
    .abort      (abort),
    .step_en    (step_en),
    .cwccw      (cwccw),
    .fushs      (fushs),
    .onoff      (onoff),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_left (steps_left),
    .position   (position)
  );

  always #5 clk = ~clk;

  // cyc == c during the cycle that follows the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit              is_done;
    int              cyc;
    logic [STEP_W-1:0] sl;
    bit              cw;
    bit              fu;
    bit              ab;
    logic [POS_W-1:0] pos;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [POS_W-1:0] pexp(input int v);
    return POS_EN ? POS_W'(v) : '0;
  endfunction

  task automatic push_step(input int c, input int sl, input bit cw, input bit fu, input int pos);
    ev_t e;
    e.is_done = 1'b0; e.cyc = c; e.sl = STEP_W'(sl); e.cw = cw; e.fu = fu;
    e.ab = 1'b0; e.pos = pexp(pos);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int sl, input bit ab, input bit cw, input bit fu,
                           input int pos);
    ev_t e;
    e.is_done = 1'b1; e.cyc = c; e.sl = STEP_W'(sl); e.cw = cw; e.fu = fu;
    e.ab = ab; e.pos = pexp(pos);
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic check_event(input bit is_done);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event @cycle %0d: got %s pulse, required none",
               cyc, is_done ? "done" : "step_en");
    end else begin
      n_pass++;
      e = exp_q.pop_front();
      chk("ev_kind_is_done", 32'(is_done), 32'(e.is_done));
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_steps_left", 32'(steps_left), 32'(e.sl));
      chk("ev_cwccw", 32'(cwccw), 32'(e.cw));
      chk("ev_fushs", 32'(fushs), 32'(e.fu));
      chk("ev_aborted", 32'(aborted), 32'(e.ab));
      chk("ev_position", 32'(position), 32'(e.pos));
      chk("ev_onoff", 32'(onoff), 32'(!e.is_done));
      chk("ev_busy", 32'(busy), 32'(!e.is_done));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (step_en) check_event(1'b0);
      if (done)    check_event(1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change at negedges, sampled on the following rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Presents a command for one cycle; accept edge ends the current cycle.
  task automatic issue(input logic d, input logic h, input int s);
    cmd_dir   = d;
    cmd_half  = h;
    cmd_steps = STEP_W'(s);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_step_en"}, 32'(step_en), 0);
    chk({tag, "_cwccw"}, 32'(cwccw), 0);
    chk({tag, "_fushs"}, 32'(fushs), 0);
    chk({tag, "_onoff"}, 32'(onoff), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
    chk({tag, "_steps_left"}, 32'(steps_left), 0);
    chk({tag, "_position"}, 32'(position), 0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    int a, a2, a3, a4, a5;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // Normal move: 3 full steps clockwise, with a busy-time command in RUN.
    a = cyc + 1;
    push_step(a + 5,  2, 1'b1, 1'b0, 1);
    push_step(a + 9,  1, 1'b1, 1'b0, 2);
    push_step(a + 13, 0, 1'b1, 1'b0, 3);
    push_done(a + 17, 0, 1'b0, 1'b1, 1'b0, 3);
    issue(1'b1, 1'b0, 3);
    for (int c = a; c <= a + 16; c++) begin
      wait_to(c);
      chk("m1_onoff_high", 32'(onoff), 1);
      if (c == a + 7) begin
        cmd_dir = 1'b0; cmd_half = 1'b1; cmd_steps = STEP_W'(7); cmd_valid = 1'b1;
      end
      if (c == a + 8) chk("busy_cmd_ready", 32'(cmd_ready), 0);
      if (c == a + 10) begin
        chk("busy_cwccw", 32'(cwccw), 1);
        chk("busy_fushs", 32'(fushs), 0);
        chk("busy_steps_left", 32'(steps_left), 1);
        cmd_valid = 1'b0;
      end
    end

    // Back-to-back: accepted in the done cycle, 2 half steps counter-clockwise.
    wait_to(a + 17);
    chk("b2b_cmd_ready", 32'(cmd_ready), 1);
    a2 = a + 18;
    push_step(a2 + 5, 1, 1'b0, 1'b1, 2);
    push_step(a2 + 9, 0, 1'b0, 1'b1, 1);
    push_done(a2 + 13, 0, 1'b0, 1'b0, 1'b1, 1);
    issue(1'b0, 1'b1, 2);

    // Null move: done the cycle after accept, motor never energised.
    wait_to(a2 + 16);
    a3 = cyc + 1;
    push_done(a3, 0, 1'b0, 1'b1, 1'b0, 1);
    issue(1'b1, 1'b0, 0);
    for (int c = a3; c <= a3 + 3; c++) begin
      wait_to(c);
      chk("null_onoff", 32'(onoff), 0);
      chk("null_busy", 32'(busy), 0);
    end

    // Abort on the edge that would launch step 2 of 5.
    wait_to(a3 + 5);
    a4 = cyc + 1;
    push_step(a4 + 5, 4, 1'b1, 1'b0, 2);
    push_done(a4 + 12, 4, 1'b1, 1'b1, 1'b0, 2);
    issue(1'b1, 1'b0, 5);
    wait_to(a4 + 8);
    abort = 1'b1;
    wait_to(a4 + 9);
    abort = 1'b0;
    chk("abort_aborted", 32'(aborted), 1);
    chk("abort_steps_left", 32'(steps_left), 4);
    chk("abort_hold_onoff", 32'(onoff), 1);
    wait_to(a4 + 10);
    abort = 1'b1;               // in HOLD: no effect on timing
    wait_to(a4 + 11);
    abort = 1'b0;
    wait_to(a4 + 13);
    abort = 1'b1;               // in IDLE: no effect, aborted stays sticky
    wait_to(a4 + 14);
    abort = 1'b0;
    wait_to(a4 + 15);
    chk("idle_abort_aborted", 32'(aborted), 1);
    chk("idle_abort_busy", 32'(busy), 0);

    // Reset asserted mid-RUN, away from any clock edge.
    wait_to(a4 + 16);
    a5 = cyc + 1;
    push_step(a5 + 5, 2, 1'b1, 1'b0, 3);
    issue(1'b1, 1'b0, 3);
    wait_to(a5 + 7);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid_run");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (25) @(negedge clk);
    chk("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
